// File: rtl/sevenseg_capture.sv
// sevenseg_capture: recovers the four BCD digits shown on a multiplexed
// seven-segment display by watching its anode and segment lines.
module sevenseg_capture #(
    parameter int unsigned SETTLE_CYCLES    = 4,
    parameter bit          ANODE_ACTIVE_LOW = 1'b1,
    parameter bit          SEG_ACTIVE_LOW   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Digit4,
    input  logic       Digit3,
    input  logic       Digit2,
    input  logic       Digit1,
    input  logic       LedA,
    input  logic       LedB,
    input  logic       LedC,
    input  logic       LedD,
    input  logic       LedE,
    input  logic       LedF,
    input  logic       LedG,
    input  logic       clear,
    output logic [3:0] min_ten,
    output logic [3:0] min_one,
    output logic [3:0] sec_ten,
    output logic [3:0] sec_one,
    output logic       frame_valid,
    output logic [3:0] digit_seen,
    output logic       pattern_err
);

    localparam int unsigned IN_W  = 11;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(SETTLE_CYCLES - 2);
    // Raw level of every line when nothing is driven; XOR with it normalizes to active-high.
    localparam logic [IN_W-1:0] RAW_IDLE = {{4{ANODE_ACTIVE_LOW}}, {7{SEG_ACTIVE_LOW}}};
    localparam logic [3:0] BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HELD
    } state_t;

    // {legal, value} for a segment vector ordered {a,b,c,d,e,f,g}.
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1111110:             r = {1'b1, 4'd0};
            7'b0110000:             r = {1'b1, 4'd1};
            7'b1101101:             r = {1'b1, 4'd2};
            7'b1111001:             r = {1'b1, 4'd3};
            7'b0110011:             r = {1'b1, 4'd4};
            7'b1011011:             r = {1'b1, 4'd5};
            7'b1011111, 7'b0011111: r = {1'b1, 4'd6};
            7'b1110000, 7'b1110010: r = {1'b1, 4'd7};
            7'b1111111:             r = {1'b1, 4'd8};
            7'b1111011, 7'b1110011: r = {1'b1, 4'd9};
            7'b0000000:             r = {1'b1, BLANK};
            default:                r = {1'b0, BLANK};
        endcase
        return r;
    endfunction

    // Position of the active anode; only meaningful for a one-hot input.
    function automatic logic [1:0] anode_index(input logic [3:0] a);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (a[i]) r = 2'(i);
        end
        return r;
    endfunction

    logic [IN_W-1:0]  raw;
    logic [IN_W-1:0]  sync1;
    logic [IN_W-1:0]  sync2;
    logic [IN_W-1:0]  sample;
    logic [IN_W-1:0]  prev;
    logic [CNT_W-1:0] stab_cnt;
    state_t           state;
    logic [3:0]       shadow [4];

    logic [3:0] anodes;
    logic [6:0] segs;
    logic       single;
    logic       changed;
    logic       reach;
    logic       accept;
    logic       multi_err;
    logic [4:0] dec;
    logic [1:0] idx;

    assign raw       = {Digit4, Digit3, Digit2, Digit1, LedA, LedB, LedC, LedD, LedE, LedF, LedG};
    assign sample    = sync2 ^ RAW_IDLE;
    assign anodes    = sample[10:7];
    assign segs      = sample[6:0];
    assign single    = (anodes != 4'd0) && ((anodes & (anodes - 4'd1)) == 4'd0);
    assign changed   = (sample != prev);
    // True on the one cycle the counter steps onto its saturation value.
    assign reach     = !changed && (stab_cnt == CNT_PRE);
    assign accept    = (state == SETTLE) && reach;
    assign multi_err = reach && (anodes != 4'd0) && !single;
    assign dec       = decode(segs);
    assign idx       = anode_index(anodes);

    // Two-flop synchronizer for all display lines.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= RAW_IDLE;
            sync2 <= RAW_IDLE;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Stability tracking, capture FSM, shadow registers and frame publication.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev        <= '0;
            stab_cnt    <= '0;
            state       <= IDLE;
            for (int i = 0; i < 4; i++) shadow[i] <= BLANK;
            min_ten     <= BLANK;
            min_one     <= BLANK;
            sec_ten     <= BLANK;
            sec_one     <= BLANK;
            digit_seen  <= 4'd0;
            frame_valid <= 1'b0;
            pattern_err <= 1'b0;
        end else begin
            prev <= sample;

            if (changed) begin
                stab_cnt <= '0;
            end else if (stab_cnt != CNT_MAX) begin
                stab_cnt <= stab_cnt + 8'd1;
            end

            if (changed) begin
                state <= single ? SETTLE : IDLE;
            end else if (accept) begin
                state <= HELD;
            end

            frame_valid <= 1'b0;
            if (clear) begin
                digit_seen  <= 4'd0;
                pattern_err <= 1'b0;
            end else begin
                if (digit_seen == 4'hF) begin
                    min_ten     <= shadow[3];
                    min_one     <= shadow[2];
                    sec_ten     <= shadow[1];
                    sec_one     <= shadow[0];
                    frame_valid <= 1'b1;
                    digit_seen  <= 4'd0;
                end
                if (accept) begin
                    if (dec[4]) begin
                        shadow[idx]     <= dec[3:0];
                        digit_seen[idx] <= 1'b1;
                    end else begin
                        pattern_err <= 1'b1;
                    end
                end
                if (multi_err) begin
                    pattern_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/sevenseg_capture.md
SEVENSEG_CAPTURE -- requirements
Module: sevenseg_capture

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: consecutive identical samples required before a digit is accepted; legal range 2..255.
REQ-002 Parameter ANODE_ACTIVE_LOW, default 1: 1 means Digit1..Digit4 select a digit when driven 0.
REQ-003 Parameter SEG_ACTIVE_LOW, default 1: 1 means LedA..LedG light a segment when driven 0.
REQ-004 clk  in  1  the single system clock; all logic is on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 Digit4, Digit3, Digit2, Digit1  in  1 each  multiplexed anode lines, asynchronous to the decoder.
REQ-007 LedA..LedG  in  1 each  segment lines, asynchronous to the decoder.
REQ-008 clear  in  1  synchronous pulse; discards the partial frame and clears pattern_err.
REQ-009 min_ten, min_one, sec_ten, sec_one  out  4 each  last complete decoded frame, BCD; 4'hF means blank.
REQ-010 frame_valid  out  1  one-cycle pulse when the four outputs update.
REQ-011 digit_seen  out  4  per-digit capture flags for the current partial frame; bit3 is Digit4 and bit0 is Digit1.
REQ-012 pattern_err  out  1  sticky flag for an illegal stable pattern or a stable multi-anode condition.

Function
REQ-013 All 11 inputs shall pass through a 2-flop synchronizer, then be normalized to active-high according to the parameters.
REQ-014 The block shall keep the previous normalized sample; stab_cnt shall clear when the sample changes and otherwise increment, saturating at SETTLE_CYCLES-1.
REQ-015 The FSM shall have three states: IDLE (zero anodes active), SETTLE (exactly one anode active, counting) and HELD (digit accepted, waiting for change).
REQ-016 Transitions:
- any sample change goes to SETTLE if exactly one anode is active, else to IDLE;
- SETTLE goes to HELD on the cycle stab_cnt reaches SETTLE_CYCLES-1;
- HELD does not re-accept the same unchanged sample.
REQ-017 Digit mapping: Digit4 -> min_ten, Digit3 -> min_one, Digit2 -> sec_ten, Digit1 -> sec_one.
REQ-018 Decode uses segment vector {a,b,c,d,e,f,g}:
- 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
- 5=1011011, 6=1011111 or 0011111, 7=1110000 or 1110010
- 8=1111111, 9=1111011 or 1110011
- 0000000 = blank (4'hF)
REQ-019 On acceptance of a legal pattern, the value shall be written to that digit's shadow register and the corresponding digit_seen bit set, in the same cycle as the SETTLE->HELD transition.
REQ-020 On acceptance of an illegal pattern, pattern_err shall be set, the shadow register and digit_seen left unchanged, and the state shall still go to HELD.
REQ-021 A multi-anode sample that stays stable for SETTLE_CYCLES shall set pattern_err once and capture nothing.
REQ-022 Re-capture of an already-seen digit shall overwrite its shadow register; the newest value wins.
REQ-023 On the cycle after digit_seen becomes 4'b1111:
- all four shadow registers copy to the outputs;
- frame_valid pulses for one cycle;
- digit_seen clears to 0.
REQ-024 Latency: 2 sync cycles + SETTLE_CYCLES from the input edge to digit_seen, plus 1 cycle to frame_valid.
REQ-025 clear coinciding with an acceptance: clear wins, so no capture occurs and digit_seen = 0.
REQ-026 clear does not affect the published outputs or the FSM sample history.
REQ-027 Outputs shall hold their values between frames; no glitch is allowed when an anode changes mid-settle.

Reset
REQ-028 Reset values:
- sync flops and previous sample = inactive;
- stab_cnt = 0, state = IDLE;
- digit outputs and shadows = 4'hF;
- digit_seen = 0, frame_valid = 0, pattern_err = 0.
REQ-029 Reset asserted mid-SETTLE or mid-frame shall abandon the partial capture with no frame_valid pulse.

Verification
REQ-030 Scan 1,2,3,4 (Digit4..Digit1), each held 10 cycles, default parameters -> one frame_valid pulse; min_ten=1, min_one=2, sec_ten=3, sec_one=4; pattern_err=0.
REQ-031 Digit2 active with segments toggling every 3 cycles for 30 cycles -> no capture; digit_seen[1] stays 0.
REQ-032 Digit1 held stable with segments 1001001 -> pattern_err=1 and digit_seen=0; a later clear pulse -> pattern_err=0.
REQ-033 Digit4 and Digit3 active together for 8 cycles -> pattern_err=1 and no digit_seen bit set.
REQ-034 Digit1 shows 7 then 9 before the remaining digits are scanned (digits 0,5,blank) -> sec_one=9, min_ten=0, min_one=5, sec_ten=F.
REQ-035 Reset asserted after three digits are captured -> digit_seen=0, outputs=F; the next full scan produces exactly one frame_valid.
